motor_ramp_driver: RTL and testbench
====================================

Name: motor_ramp_driver

Overview:
Downstream of the line-tracker FSM and the obstacle stop flag. Converts the 3-bit drive mode into per-wheel direction bits and a PWM enable for each wheel. Wheel speed ramps toward its target duty instead of stepping. A wheel that must reverse first ramps down to zero, and only then is its direction flipped, which protects the H-bridge and gearbox.

Parameters:
CNT_W, 10, PWM counter / duty width; PWM period = 2^CNT_W clk cycles
RAMP_DIV, 50000, clk cycles per ramp tick (min 1)
STEP, 16, duty change per ramp tick (min 1)
DUTY_STRAIGHT, 900, target duty for go_straight wheels
DUTY_TURN, 700, target duty for the driven wheel in turn_left/turn_right
DUTY_SHARP, 600, target duty for both wheels in sharp turns

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
mode  input  3  000 turn_left, 001 turn_right, 010 go_straight, 011 stop_state, 100 sharp_turn_left, 101 sharp_turn_right, 110/111 treated as stop_state
stop  input  1  obstacle stop; level-sensitive, overrides mode
pwm_left  output  1  left wheel PWM enable
pwm_right  output  1  right wheel PWM enable
dir_left  output  2  left H-bridge direction: 10 forward, 01 reverse, 00 coast
dir_right  output  2  right H-bridge direction, same encoding
duty_left  output  CNT_W  current applied left duty
duty_right  output  CNT_W  current applied right duty
settled  output  1  both wheels at target, no drain in progress

Behaviour:
- Reset values: pwm_* 0, dir_* 00, duty_* 0, settled 1, PWM counter 0, prescaler 0, both wheel FSMs in IDLE.
- Target table, written as (left dir, duty) / (right dir, duty):
  - turn_left: (hold, 0) / (10, DUTY_TURN)
  - turn_right: (10, DUTY_TURN) / (hold, 0)
  - go_straight: (10, DUTY_STRAIGHT) / (10, DUTY_STRAIGHT)
  - sharp_turn_left: (01, DUTY_SHARP) / (10, DUTY_SHARP)
  - sharp_turn_right: (10, DUTY_SHARP) / (01, DUTY_SHARP)
  - stop_state and 110/111: (hold, 0) / (hold, 0)
  - "hold" means no direction request; the current dir is kept while the duty ramps to 0.
- mode and stop are registered once; all decisions use the registered values, so there is 1 cycle of input latency.
- Prescaler: counts 0..RAMP_DIV-1 and wraps. ramp_tick pulses for 1 cycle at RAMP_DIV-1. Runs freely; not reset by mode changes.
- Per-wheel FSM:
  - IDLE: duty 0, dir 00. If the target duty is nonzero, load dir with the requested direction and go to RUN in the same cycle. Ramping starts at the next ramp_tick.
  - RUN: on each ramp_tick, move duty toward target by STEP, clamped to the target (no overshoot). When duty reaches 0 and the target is 0, go to IDLE and set dir to 00.
  - RUN to DRAIN: taken when the requested dir is non-hold and differs from the current dir.
  - DRAIN: on each ramp_tick, duty decreases by STEP, clamped at 0. dir keeps its old value. When duty = 0, next cycle: dir takes the new direction and the FSM returns to RUN.
  - A target change during DRAIN only updates the direction latched at exit. If the new request returns to the current dir, leave DRAIN immediately to RUN without reaching 0.
- stop = 1 (registered):
  - Next cycle: duty_* = 0, dir_* = 00, pwm_* = 0, both FSMs in IDLE. The ramp is bypassed.
  - While stop is held, the block stays there. When stop falls, wheels ramp up from 0 per the current mode.
- PWM:
  - Free-running CNT_W-bit counter wraps 2^CNT_W-1 to 0.
  - pwm_x = (counter < applied_duty_x), registered.
  - applied_duty is loaded from duty_x only when counter = 2^CNT_W-1, so there are no mid-period glitches.
  - Exception: on stop, applied_duty is cleared immediately.
  - Duty 0 gives a constant low output. The maximum duty 2^CNT_W-1 gives high for all but 1 cycle per period.
- Arithmetic: use a CNT_W+1-bit intermediate for duty ± STEP so that neither underflow below 0 nor overshoot past the target can wrap.
- settled = both FSMs not in DRAIN and duty_x equals target_x for both wheels. It is combinational from registers.
- Simultaneous events:
  - stop and ramp_tick in the same cycle: stop wins.
  - mode change on a ramp_tick cycle: the tick applies toward the old target, then the new target applies from the next tick.
- Reset mid-operation: all outputs return asynchronously to their reset values in the same cycle.

Test Plan:
Bench parameters: CNT_W=4, RAMP_DIV=4, STEP=3, DUTY_STRAIGHT=12, DUTY_TURN=9, DUTY_SHARP=6.
1. Reset, then mode=010 -> dir_left=dir_right=10; duty steps 0,3,6,9,12, one step every 4 clk; then holds at 12; settled=1 after the 4th tick; pwm_x high for 12 of every 16 cycles.
2. From steady go_straight, mode=100 -> left enters DRAIN with dir 10; duty 12→9→6→3→0; then dir_left=01 and duty ramps to 6. Right ramps 12→9→6 and holds 6 with dir 10. settled=0 throughout the drain.
3. Mid-ramp (duty 6), raise stop for 1 cycle -> 2 cycles after stop, duty_*=0, dir_*=00, pwm_*=0. After stop falls, ramp restarts from 0.
4. mode=011 from turn_right (left at 9) -> duty_left ramps 9,6,3,0; dir_left stays 10 until duty reaches 0, then becomes 00; dir_right stays 00.
5. mode=110 from go_straight -> same behaviour as stop_state: both wheels ramp to 0, then dir 00.
6. During the scenario-2 drain, at duty 6, switch mode back to 010 -> left leaves DRAIN without reaching 0, keeps dir 10 and ramps up 6→9→12. Also assert rst mid-ramp -> all outputs are 0 or 00 in the same cycle.

Source files
------------

// File: rtl/motor_ramp_driver_if.sv
// Command/status bundle for motor_ramp_driver.
//   mode       drive mode from the line tracker (3 bits)
//   stop       obstacle stop, level-sensitive, overrides mode
//   pwm_*      per-wheel PWM enable
//   dir_*      per-wheel H-bridge direction (10 fwd, 01 rev, 00 coast)
//   duty_*     per-wheel currently applied duty
//   settled    both wheels at target with no drain in progress
// master: the controller side driving mode/stop. slave: the driver.
interface motor_ramp_driver_if #(
   parameter int CNT_W = 10
);
   logic [2:0]       mode;
   logic             stop;
   logic             pwm_left;
   logic             pwm_right;
   logic [1:0]       dir_left;
   logic [1:0]       dir_right;
   logic [CNT_W-1:0] duty_left;
   logic [CNT_W-1:0] duty_right;
   logic             settled;

   modport master (
      output mode, stop,
      input  pwm_left, pwm_right, dir_left, dir_right,
      input  duty_left, duty_right, settled
   );

   modport slave (
      input  mode, stop,
      output pwm_left, pwm_right, dir_left, dir_right,
      output duty_left, duty_right, settled
   );
endinterface

// File: rtl/motor_ramp_driver.sv
// Two-wheel motor driver with ramped duty and safe reversal.
// Decodes the registered drive mode into per-wheel direction/duty targets,
// ramps each wheel's duty by STEP every RAMP_DIV cycles, drains a wheel to
// zero before flipping its direction, and produces glitch-free PWM.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  motor_ramp_driver_if.slave (mode/stop in; pwm/dir/duty/settled out)

// Per-wheel ramp FSM: IDLE -> RUN, RUN <-> DRAIN on direction reversal.
module mrd_wheel #(
   parameter int CNT_W = 10,
   parameter int STEP  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_i,     // ramp tick
   input  logic             stop_i,     // registered stop
   input  logic [1:0]       req_dir_i,  // 00 = hold (no request)
   input  logic [CNT_W-1:0] tgt_i,
   output logic [CNT_W-1:0] duty_o,
   output logic [1:0]       dir_o,
   output logic             drain_o
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [CNT_W:0] STEP_E = (CNT_W+1)'(STEP);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [1:0]       dir_q, dir_d;

   // One STEP toward tgt, clamped; the extra bit keeps both the up-sum and
   // the down-difference from wrapping.
   function automatic logic [CNT_W-1:0] step_toward(
      input logic [CNT_W-1:0] cur,
      input logic [CNT_W-1:0] tgt
   );
      logic [CNT_W:0] c, t, up, dn;
      c  = {1'b0, cur};
      t  = {1'b0, tgt};
      up = c + STEP_E;
      dn = c - STEP_E;
      if (c < t)
         step_toward = (up >= t) ? tgt : up[CNT_W-1:0];
      else if (c >= t + STEP_E)
         step_toward = dn[CNT_W-1:0];
      else
         step_toward = tgt;
   endfunction

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      if (stop_i) begin
         state_d = S_IDLE;
         duty_d  = '0;
         dir_d   = 2'b00;
      end else begin
         case (state_q)
            S_IDLE: begin
               duty_d = '0;
               dir_d  = 2'b00;
               if (tgt_i != '0) begin
                  dir_d   = req_dir_i;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (req_dir_i != 2'b00 && req_dir_i != dir_q)
                  state_d = S_DRAIN;
               else if (duty_q == '0 && tgt_i == '0) begin
                  state_d = S_IDLE;
                  dir_d   = 2'b00;
               end else if (tick_i)
                  duty_d = step_toward(duty_q, tgt_i);
            end
            S_DRAIN: begin
               // Only two real directions exist, so the direction to take at
               // exit is always the swap of the current one.
               if (req_dir_i == dir_q)
                  state_d = S_RUN;
               else if (duty_q == '0) begin
                  dir_d   = {dir_q[0], dir_q[1]};
                  state_d = S_RUN;
               end else if (tick_i)
                  duty_d = step_toward(duty_q, '0);
            end
            default: begin
               state_d = S_IDLE;
               duty_d  = '0;
               dir_d   = 2'b00;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         duty_q  <= '0;
         dir_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         dir_q   <= dir_d;
      end
   end

   assign duty_o  = duty_q;
   assign dir_o   = dir_q;
   assign drain_o = (state_q == S_DRAIN);
endmodule

module motor_ramp_driver #(
   parameter int CNT_W         = 10,
   parameter int RAMP_DIV      = 50000,
   parameter int STEP          = 16,
   parameter int DUTY_STRAIGHT = 900,
   parameter int DUTY_TURN     = 700,
   parameter int DUTY_SHARP    = 600
) (
   input logic                clk,
   input logic                rst,
   motor_ramp_driver_if.slave bus
);
   localparam int NW    = 2;  // lane 0 = left, lane 1 = right
   localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(RAMP_DIV - 1);

   localparam logic [CNT_W-1:0] D_STR = CNT_W'(DUTY_STRAIGHT);
   localparam logic [CNT_W-1:0] D_TRN = CNT_W'(DUTY_TURN);
   localparam logic [CNT_W-1:0] D_SHP = CNT_W'(DUTY_SHARP);
   localparam logic [1:0]       FWD   = 2'b10;
   localparam logic [1:0]       REV   = 2'b01;

   logic [2:0]                  mode_q;
   logic                        stop_q;
   logic [PRE_W-1:0]            pre_q;
   logic                        ramp_tick;
   logic [NW-1:0][1:0]          req_dir;
   logic [NW-1:0][CNT_W-1:0]    tgt;
   logic [NW-1:0][CNT_W-1:0]    duty;
   logic [NW-1:0][1:0]          dir;
   logic [NW-1:0]               drain;
   logic [CNT_W-1:0]            cnt_q;
   logic [NW-1:0][CNT_W-1:0]    applied_q;
   logic [NW-1:0]               pwm_q;

   // Inputs registered once. mode resets to stop_state so that targets are
   // zero out of reset and settled reads 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= 3'b011;
         stop_q <= 1'b0;
      end else begin
         mode_q <= bus.mode;
         stop_q <= bus.stop;
      end
   end

   // Free-running ramp prescaler, independent of mode changes.
   assign ramp_tick = (pre_q == PRE_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            pre_q <= '0;
      else if (ramp_tick) pre_q <= '0;
      else                pre_q <= pre_q + 1'b1;
   end

   // Target table; hold (00) with duty 0 means "ramp down, keep direction".
   always_comb begin
      req_dir = '0;
      tgt     = '0;
      if (!stop_q) begin
         case (mode_q)
            3'b000: begin req_dir[1] = FWD; tgt[1] = D_TRN; end
            3'b001: begin req_dir[0] = FWD; tgt[0] = D_TRN; end
            3'b010: begin
               req_dir[0] = FWD; tgt[0] = D_STR;
               req_dir[1] = FWD; tgt[1] = D_STR;
            end
            3'b100: begin
               req_dir[0] = REV; tgt[0] = D_SHP;
               req_dir[1] = FWD; tgt[1] = D_SHP;
            end
            3'b101: begin
               req_dir[0] = FWD; tgt[0] = D_SHP;
               req_dir[1] = REV; tgt[1] = D_SHP;
            end
            default: ;
         endcase
      end
   end

   for (genvar w = 0; w < NW; w++) begin : g_wheel
      mrd_wheel #(.CNT_W(CNT_W), .STEP(STEP)) u_wheel (
         .clk       (clk),
         .rst       (rst),
         .tick_i    (ramp_tick),
         .stop_i    (stop_q),
         .req_dir_i (req_dir[w]),
         .tgt_i     (tgt[w]),
         .duty_o    (duty[w]),
         .dir_o     (dir[w]),
         .drain_o   (drain[w])
      );
   end

   // PWM: applied duty only reloads at end of period so a period never
   // mixes two duties; stop clears it at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         applied_q <= '0;
         pwm_q     <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
         if (stop_q) begin
            applied_q <= '0;
            pwm_q     <= '0;
         end else begin
            if (cnt_q == '1) applied_q <= duty;
            for (int w = 0; w < NW; w++) pwm_q[w] <= (cnt_q < applied_q[w]);
         end
      end
   end

   assign bus.pwm_left   = pwm_q[0];
   assign bus.pwm_right  = pwm_q[1];
   assign bus.dir_left   = dir[0];
   assign bus.dir_right  = dir[1];
   assign bus.duty_left  = duty[0];
   assign bus.duty_right = duty[1];
   assign bus.settled    = ~|drain && (duty == tgt);
endmodule

// File: tb/tb_motor_ramp_driver.sv
// Directed bench for motor_ramp_driver (CNT_W=4, RAMP_DIV=4, STEP=3,
// straight 12, turn 9, sharp 6). Timing is tracked as e = number of rising
// edges since reset release; ramp ticks act on edges where e is a multiple
// of 4, mode/stop act one edge after being driven.
module tb_motor_ramp_driver;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   e = 0;

   motor_ramp_driver_if #(.CNT_W(CNT_W)) bus ();

   motor_ramp_driver #(
      .CNT_W(CNT_W), .RAMP_DIV(4), .STEP(3),
      .DUTY_STRAIGHT(12), .DUTY_TURN(9), .DUTY_SHARP(6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Advance n edges, then settle 1ns past the edge for sampling/driving.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
      e += n;
   endtask

   task automatic goto(input int k);
      if (k > e) step(k - e);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      bus.mode = 3'b011;
      bus.stop = 1'b0;
      step(3);
      rst = 1'b0;
      e   = 0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      step(1);
      checks++;
      if (bus.duty_left !== 4'd0 || bus.duty_right !== 4'd0) begin
         errors++; $display("FAIL reset_duty got %0d/%0d expected 0/0", bus.duty_left, bus.duty_right);
      end
      checks++;
      if (bus.dir_left !== 2'b00 || bus.dir_right !== 2'b00) begin
         errors++; $display("FAIL reset_dir got %b/%b expected 00/00", bus.dir_left, bus.dir_right);
      end
      checks++;
      if (bus.pwm_left !== 1'b0 || bus.pwm_right !== 1'b0 || bus.settled !== 1'b1) begin
         errors++; $display("FAIL reset_pwm_settled got %b%b/%b expected 00/1", bus.pwm_left, bus.pwm_right, bus.settled);
      end
      rst = 1'b0;
   endtask

   task automatic test_straight();
      int cl, cr;
      do_reset();
      bus.mode = 3'b010;
      goto(2);
      checks++;
      if (bus.dir_left !== 2'b10 || bus.dir_right !== 2'b10 || bus.duty_left !== 4'd0) begin
         errors++; $display("FAIL straight_start got dir %b/%b duty %0d expected 10/10 0", bus.dir_left, bus.dir_right, bus.duty_left);
      end
      for (int k = 1; k <= 4; k++) begin
         goto(4*k - 1);
         checks++;
         if (bus.duty_left !== 4'(3*(k-1)) || bus.duty_right !== 4'(3*(k-1)) || bus.settled !== 1'b0) begin
            errors++; $display("FAIL straight_pre e=%0d got %0d/%0d s=%b expected %0d/%0d s=0", e, bus.duty_left, bus.duty_right, bus.settled, 3*(k-1), 3*(k-1));
         end
         goto(4*k);
         checks++;
         if (bus.duty_left !== 4'(3*k) || bus.duty_right !== 4'(3*k)) begin
            errors++; $display("FAIL straight_tick e=%0d got %0d/%0d expected %0d", e, bus.duty_left, bus.duty_right, 3*k);
         end
      end
      checks++;
      if (bus.settled !== 1'b1) begin
         errors++; $display("FAIL straight_settled got %b expected 1", bus.settled);
      end
      goto(36);
      cl = 0; cr = 0;
      repeat (16) begin
         step(1);
         cl += int'(bus.pwm_left);
         cr += int'(bus.pwm_right);
      end
      checks++;
      if (cl != 12 || cr != 12) begin
         errors++; $display("FAIL straight_pwm got %0d/%0d high expected 12/12", cl, cr);
      end
      checks++;
      if (bus.duty_left !== 4'd12 || bus.settled !== 1'b1) begin
         errors++; $display("FAIL straight_hold got %0d s=%b expected 12 s=1", bus.duty_left, bus.settled);
      end
   endtask

   task automatic reach_straight();
      do_reset();
      bus.mode = 3'b010;
      goto(20);
   endtask

   task automatic test_sharp_drain();
      reach_straight();
      bus.mode = 3'b100;
      goto(22);
      checks++;
      if (bus.dir_left !== 2'b10 || bus.settled !== 1'b0) begin
         errors++; $display("FAIL drain_enter got dir %b s=%b expected 10 s=0", bus.dir_left, bus.settled);
      end
      goto(28);
      checks++;
      if (bus.duty_left !== 4'd6 || bus.duty_right !== 4'd6 || bus.dir_right !== 2'b10 || bus.settled !== 1'b0) begin
         errors++; $display("FAIL drain_mid got %0d/%0d dir_r %b s=%b expected 6/6 10 s=0", bus.duty_left, bus.duty_right, bus.dir_right, bus.settled);
      end
      goto(36);
      checks++;
      if (bus.duty_left !== 4'd0 || bus.dir_left !== 2'b10 || bus.settled !== 1'b0) begin
         errors++; $display("FAIL drain_zero got %0d dir %b s=%b expected 0 10 s=0", bus.duty_left, bus.dir_left, bus.settled);
      end
      goto(37);
      checks++;
      if (bus.dir_left !== 2'b01 || bus.duty_left !== 4'd0) begin
         errors++; $display("FAIL drain_flip got dir %b duty %0d expected 01 0", bus.dir_left, bus.duty_left);
      end
      goto(40);
      checks++;
      if (bus.duty_left !== 4'd3) begin
         errors++; $display("FAIL drain_rampup got %0d expected 3", bus.duty_left);
      end
      goto(44);
      checks++;
      if (bus.duty_left !== 4'd6 || bus.duty_right !== 4'd6 || bus.dir_right !== 2'b10 || bus.settled !== 1'b1) begin
         errors++; $display("FAIL drain_done got %0d/%0d dir_r %b s=%b expected 6/6 10 s=1", bus.duty_left, bus.duty_right, bus.dir_right, bus.settled);
      end
   endtask

   task automatic test_drain_abort();
      reach_straight();
      bus.mode = 3'b100;
      goto(28);
      bus.mode = 3'b010;
      goto(29);
      checks++;
      if (bus.settled !== 1'b0 || bus.duty_left !== 4'd6) begin
         errors++; $display("FAIL abort_pre got %0d s=%b expected 6 s=0", bus.duty_left, bus.settled);
      end
      goto(30);
      checks++;
      if (bus.dir_left !== 2'b10 || bus.duty_left !== 4'd6) begin
         errors++; $display("FAIL abort_exit got dir %b duty %0d expected 10 6", bus.dir_left, bus.duty_left);
      end
      goto(32);
      checks++;
      if (bus.duty_left !== 4'd9 || bus.duty_right !== 4'd9) begin
         errors++; $display("FAIL abort_up got %0d/%0d expected 9/9", bus.duty_left, bus.duty_right);
      end
      goto(36);
      checks++;
      if (bus.duty_left !== 4'd12 || bus.duty_right !== 4'd12 || bus.dir_left !== 2'b10 || bus.settled !== 1'b1) begin
         errors++; $display("FAIL abort_done got %0d/%0d dir %b s=%b expected 12/12 10 s=1", bus.duty_left, bus.duty_right, bus.dir_left, bus.settled);
      end
   endtask

   task automatic test_stop();
      do_reset();
      bus.mode = 3'b010;
      goto(9);
      bus.stop = 1'b1;
      goto(10);
      bus.stop = 1'b0;
      checks++;
      if (bus.duty_left !== 4'd6 || bus.duty_right !== 4'd6) begin
         errors++; $display("FAIL stop_latency got %0d/%0d expected 6/6", bus.duty_left, bus.duty_right);
      end
      goto(11);
      checks++;
      if (bus.duty_left !== 4'd0 || bus.duty_right !== 4'd0 || bus.dir_left !== 2'b00 || bus.dir_right !== 2'b00 ||
          bus.pwm_left !== 1'b0 || bus.pwm_right !== 1'b0) begin
         errors++; $display("FAIL stop_clear got %0d/%0d dir %b/%b pwm %b%b expected 0/0 00/00 00", bus.duty_left, bus.duty_right, bus.dir_left, bus.dir_right, bus.pwm_left, bus.pwm_right);
      end
      goto(12);
      checks++;
      if (bus.dir_left !== 2'b10 || bus.duty_left !== 4'd0) begin
         errors++; $display("FAIL stop_restart got dir %b duty %0d expected 10 0", bus.dir_left, bus.duty_left);
      end
      goto(16);
      checks++;
      if (bus.duty_left !== 4'd3 || bus.duty_right !== 4'd3) begin
         errors++; $display("FAIL stop_reramp got %0d/%0d expected 3/3", bus.duty_left, bus.duty_right);
      end
   endtask

   task automatic test_turn_to_stop();
      do_reset();
      bus.mode = 3'b001;
      goto(12);
      checks++;
      if (bus.duty_left !== 4'd9 || bus.dir_left !== 2'b10 || bus.duty_right !== 4'd0 || bus.dir_right !== 2'b00) begin
         errors++; $display("FAIL turn_right got %0d %b / %0d %b expected 9 10 / 0 00", bus.duty_left, bus.dir_left, bus.duty_right, bus.dir_right);
      end
      bus.mode = 3'b011;
      goto(16);
      checks++;
      if (bus.duty_left !== 4'd6 || bus.dir_left !== 2'b10) begin
         errors++; $display("FAIL turnstop_down got %0d %b expected 6 10", bus.duty_left, bus.dir_left);
      end
      goto(24);
      checks++;
      if (bus.duty_left !== 4'd0 || bus.dir_left !== 2'b10) begin
         errors++; $display("FAIL turnstop_zero got %0d %b expected 0 10", bus.duty_left, bus.dir_left);
      end
      goto(25);
      checks++;
      if (bus.dir_left !== 2'b00 || bus.dir_right !== 2'b00 || bus.settled !== 1'b1) begin
         errors++; $display("FAIL turnstop_coast got %b/%b s=%b expected 00/00 s=1", bus.dir_left, bus.dir_right, bus.settled);
      end
   endtask

   task automatic test_mode110();
      do_reset();
      bus.mode = 3'b010;
      goto(16);
      bus.mode = 3'b110;
      goto(20);
      checks++;
      if (bus.duty_left !== 4'd9 || bus.duty_right !== 4'd9) begin
         errors++; $display("FAIL m110_down got %0d/%0d expected 9/9", bus.duty_left, bus.duty_right);
      end
      goto(32);
      checks++;
      if (bus.duty_left !== 4'd0 || bus.duty_right !== 4'd0 || bus.dir_left !== 2'b10 || bus.dir_right !== 2'b10) begin
         errors++; $display("FAIL m110_zero got %0d/%0d dir %b/%b expected 0/0 10/10", bus.duty_left, bus.duty_right, bus.dir_left, bus.dir_right);
      end
      goto(33);
      checks++;
      if (bus.dir_left !== 2'b00 || bus.dir_right !== 2'b00 || bus.settled !== 1'b1) begin
         errors++; $display("FAIL m110_coast got %b/%b s=%b expected 00/00 s=1", bus.dir_left, bus.dir_right, bus.settled);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.mode = 3'b010;
      goto(9);
      checks++;
      if (bus.duty_left !== 4'd6) begin
         errors++; $display("FAIL areset_pre got %0d expected 6", bus.duty_left);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.duty_left !== 4'd0 || bus.duty_right !== 4'd0 || bus.dir_left !== 2'b00 || bus.dir_right !== 2'b00 ||
          bus.pwm_left !== 1'b0 || bus.pwm_right !== 1'b0 || bus.settled !== 1'b1) begin
         errors++; $display("FAIL areset_now got %0d/%0d dir %b/%b pwm %b%b s=%b expected 0/0 00/00 00 s=1", bus.duty_left, bus.duty_right, bus.dir_left, bus.dir_right, bus.pwm_left, bus.pwm_right, bus.settled);
      end
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      bus.mode = 3'b011;
      bus.stop = 1'b0;
      test_reset();
      test_straight();
      test_sharp_drain();
      test_drain_abort();
      test_stop();
      test_turn_to_stop();
      test_mode110();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
